// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and result flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ADC  = 4'd8,
    OP_SBC  = 4'd9,
    OP_SAR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_CMP  = 4'd12,
    OP_PASS = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: computes result, Z/N/C/V flags, the illegal
// opcode indication and whether the op writes the chained carry register.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags,
  output logic             illegal,
  output logic             updates_c
);

  localparam int SHW = $clog2(WIDTH);
  // WIDTH always fits in SHW+1 bits, which is the span of a widened shift amount
  localparam logic [SHW:0] W_EXT = WIDTH[SHW:0];

  alu_op_e          op_s;
  logic             add_cin_s;
  logic             sub_cin_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic             add_v_s;
  logic             sub_v_s;
  logic [SHW-1:0]   sh_s;
  logic [SHW:0]     sh_ext_s;
  logic [SHW:0]     rol_amt_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   shr_s;
  logic [WIDTH:0]   sar_s;
  logic [WIDTH-1:0] rol_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] flag_res_s;
  logic             c_s;
  logic             v_s;
  logic             ill_s;
  logic             upd_s;
  logic             cmp_s;

  assign op_s      = alu_op_e'(op);
  // Only the chained variants consume the carry register; ADD/SUB start a new chain
  assign add_cin_s = (op_s == OP_ADC) ? cin : 1'b0;
  assign sub_cin_s = (op_s == OP_SBC) ? cin : 1'b0;

  // Bit WIDTH of sum is carry-out; bit WIDTH of difference is borrow-out
  assign sum_s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin_s};
  assign diff_s  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_cin_s};
  assign add_v_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  assign sub_v_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);

  // Shifts use one extra bit so the last bit shifted out lands in a fixed spot;
  // amounts at or beyond WIDTH then naturally yield zero / sign fill.
  assign sh_s      = b[SHW-1:0];
  assign sh_ext_s  = {1'b0, sh_s};
  assign shl_s     = {1'b0, a} << sh_s;
  assign shr_s     = {a, 1'b0} >> sh_s;
  assign sar_s     = $signed({a, 1'b0}) >>> sh_s;
  // sh < 2*WIDTH, so a single conditional subtract gives sh mod WIDTH
  assign rol_amt_s = (sh_ext_s >= W_EXT) ? (sh_ext_s - W_EXT) : sh_ext_s;
  assign rol_s     = (a << rol_amt_s) | (a >> (W_EXT - rol_amt_s));

  // Opcode decode: select result, carry/overflow and side-effect indications
  always_comb begin
    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    ill_s = 1'b0;
    upd_s = 1'b0;
    cmp_s = 1'b0;
    case (op_s)
      OP_ADD, OP_ADC: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = add_v_s;
        upd_s = 1'b1;
      end
      OP_SUB, OP_SBC: begin
        res_s = diff_s[WIDTH-1:0];
        c_s   = diff_s[WIDTH];
        v_s   = sub_v_s;
        upd_s = 1'b1;
      end
      OP_CMP: begin
        res_s = a;
        c_s   = diff_s[WIDTH];
        v_s   = sub_v_s;
        upd_s = 1'b1;
        cmp_s = 1'b1;
      end
      OP_AND:  res_s = a & b;
      OP_OR:   res_s = a | b;
      OP_XOR:  res_s = a ^ b;
      OP_NOT:  res_s = ~a;
      OP_SHL: begin
        res_s = shl_s[WIDTH-1:0];
        c_s   = shl_s[WIDTH];
      end
      OP_SHR: begin
        res_s = shr_s[WIDTH:1];
        c_s   = shr_s[0];
      end
      OP_SAR: begin
        res_s = sar_s[WIDTH:1];
        c_s   = sar_s[0];
      end
      OP_ROL: begin
        res_s = rol_s;
        c_s   = (sh_s != {SHW{1'b0}}) ? rol_s[0] : 1'b0;
      end
      OP_PASS: res_s = b;
      default: ill_s = 1'b1;
    endcase
  end

  // Flag generation: CMP reports Z/N of the difference, illegal ops clear all flags
  always_comb begin
    flag_res_s = res_s;
    flags      = 4'b0000;
    if (cmp_s) begin
      flag_res_s = diff_s[WIDTH-1:0];
    end else begin
      flag_res_s = res_s;
    end
    if (ill_s) begin
      flags = 4'b0000;
    end else begin
      flags.z = (flag_res_s == {WIDTH{1'b0}});
      flags.n = flag_res_s[WIDTH-1];
      flags.c = c_s;
      flags.v = v_s;
    end
  end

  assign result    = res_s;
  assign illegal   = ill_s;
  assign updates_c = upd_s;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: stage 1 holds the accepted operands,
// stage 2 holds the registered result and flags. Keeps the carry that
// chains ADC/SBC sequences across words.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal
);

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [3:0]       s1_op_r;
  logic             carry_r;
  logic             s2_take_s;
  logic             s1_move_s;
  logic [WIDTH-1:0] res_s;
  alu_flags_t       flags_s;
  logic             ill_s;
  logic             upd_s;

  // Stage 2 can load whenever it is empty or its result leaves this cycle
  assign s2_take_s = !out_valid || out_ready;
  assign in_ready  = !s1_valid_r || s2_take_s;
  assign s1_move_s = s1_valid_r && s2_take_s;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a         (s1_a_r),
    .b         (s1_b_r),
    .op        (s1_op_r),
    .cin       (carry_r),
    .result    (res_s),
    .flags     (flags_s),
    .illegal   (ill_s),
    .updates_c (upd_s)
  );

  // Stage 1: capture an offered operation whenever the stage can advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_op_r    <= 4'd0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r  <= in_a;
        s1_b_r  <= in_b;
        s1_op_r <= in_op;
      end
    end
  end

  // Stage 2: register result and flags; hold them while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= {WIDTH{1'b0}};
      out_zero    <= 1'b0;
      out_neg     <= 1'b0;
      out_carry   <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (s2_take_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_result  <= res_s;
        out_zero    <= flags_s.z;
        out_neg     <= flags_s.n;
        out_carry   <= flags_s.c;
        out_ovf     <= flags_s.v;
        out_illegal <= ill_s;
      end
    end
  end

  // Chained carry: written by arithmetic ops in program order as they leave stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_r <= 1'b0;
    end else if (s1_move_s && upd_s) begin
      carry_r <= flags_s.c;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, backpressure,
// reset-in-flight and WIDTH=5 corner cases, then randomized traffic
// checked against an arithmetic reference model via a scoreboard.
module tb_alu_pipe;

  typedef struct packed {
    logic       ill;
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_result;
  logic [3:0] in_op;
  logic       out_zero, out_neg, out_carry, out_ovf, out_illegal;

  logic       in_valid5, in_ready5, out_valid5, out_ready5;
  logic [4:0] in_a5, in_b5, out_result5;
  logic [3:0] in_op5;
  logic       out_zero5, out_neg5, out_carry5, out_ovf5, out_illegal5;

  int   total = 0;
  int   bad = 0;
  int   taken_cnt = 0;
  int   mcarry = 0;
  bit   tab_mode = 1'b0;
  exp_t tab_exp;
  exp_t q[$];
  bit   hold_pend = 1'b0;
  exp_t hold_val;
  vec_t tab[22];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_illegal(out_illegal)
  );

  alu_pipe #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_a(in_a5), .in_b(in_b5), .in_op(in_op5), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_result(out_result5), .out_zero(out_zero5),
    .out_neg(out_neg5), .out_carry(out_carry5), .out_ovf(out_ovf5),
    .out_illegal(out_illegal5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model for WIDTH=8, written from the operation definitions
  function automatic exp_t ref_op(input int op, input int a, input int b,
                                  input int cin, output bit upd);
    exp_t e;
    int sh, sa, sb, r, sr, ci, rr, fr, res;
    bit c, v, ill;
    e = '0; upd = 1'b0; c = 1'b0; v = 1'b0; ill = 1'b0; r = 0;
    sh = b % 8;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0, 8: begin
        ci = (op == 8) ? cin : 0;
        r = a + b + ci; c = (r > 255);
        sr = sa + sb + ci; v = (sr > 127) || (sr < -128); upd = 1'b1;
      end
      1, 9, 12: begin
        ci = (op == 9) ? cin : 0;
        r = a - b - ci; c = (a < b + ci);
        sr = sa - sb - ci; v = (sr > 127) || (sr < -128); upd = 1'b1;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = a << sh; c = (sh != 0) && (((a >> (8 - sh)) & 1) == 1); end
      7: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      10: begin r = sa >>> sh; c = (sh != 0) && (((sa >>> (sh - 1)) & 1) == 1); end
      11: begin
        r = ((a << sh) | (a >> (8 - sh))) & 255;
        c = (sh != 0) && ((r & 1) == 1);
      end
      13: r = b;
      default: ill = 1'b1;
    endcase
    rr  = r & 255;
    res = (op == 12) ? a : rr;
    fr  = rr;
    if (ill) begin
      e.ill = 1'b1;
    end else begin
      e.res = res[7:0];
      e.z = (fr == 0);
      e.n = (fr >= 128);
      e.c = c;
      e.v = v;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic il, input logic [7:0] r,
                              input logic z, input logic n, input logic c, input logic v);
    vec_t t;
    t.op = op; t.a = a; t.b = b;
    t.e = {il, r, z, n, c, v};
    return t;
  endfunction

  // One clock: sample/check outputs at the falling edge, then advance past the rising edge
  task automatic cycle(output bit acc);
    exp_t act, e;
    bit upd;
    @(negedge clk);
    act = {out_illegal, out_result, out_zero, out_neg, out_carry, out_ovf};
    if (hold_pend) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {18'd0, act}, {18'd0, hold_val});
    end
    hold_pend = out_valid && !out_ready;
    hold_val  = act;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output actual=%0h required=none", act);
      end else begin
        e = q.pop_front();
        chk("out", {18'd0, act}, {18'd0, e});
        taken_cnt++;
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e = ref_op(int'(in_op), int'(in_a), int'(in_b), mcarry, upd);
      if (upd) mcarry = e.c;
      q.push_back(tab_mode ? tab_exp : e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      cycle(acc);
      n++;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
  endtask

  task automatic run5(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [9:0] exp);
    in_valid5 = 1'b1; in_op5 = op; in_a5 = a; in_b5 = b;
    @(posedge clk); #1;
    in_valid5 = 1'b0;
    @(posedge clk); #1;
    chk("w5_valid", {31'd0, out_valid5}, 32'd1);
    chk("w5_out", {22'd0, out_illegal5, out_result5, out_zero5, out_neg5, out_carry5, out_ovf5},
        {22'd0, exp});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int i, t0;
    logic [3:0] bp_ops[4];

    tab[0]  = mk(4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tab[1]  = mk(4'd8,  8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[2]  = mk(4'd1,  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    tab[3]  = mk(4'd1,  8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[4]  = mk(4'd12, 8'h05, 8'h05, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    tab[5]  = mk(4'd6,  8'h81, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    tab[6]  = mk(4'd10, 8'h80, 8'h03, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[7]  = mk(4'd11, 8'h81, 8'h01, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    tab[8]  = mk(4'd6,  8'h81, 8'h00, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[9]  = mk(4'd14, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[10] = mk(4'd9,  8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[11] = mk(4'd9,  8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[12] = mk(4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    tab[13] = mk(4'd2,  8'hAA, 8'h0F, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[14] = mk(4'd3,  8'hA0, 8'h05, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[15] = mk(4'd4,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[16] = mk(4'd5,  8'h0F, 8'h33, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[17] = mk(4'd13, 8'h12, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tab[18] = mk(4'd7,  8'h01, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tab[19] = mk(4'd15, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[20] = mk(4'd11, 8'h81, 8'h00, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    tab[21] = mk(4'd12, 8'h02, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0);

    rst = 1'b1;
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 4'd0; out_ready = 1'b0;
    in_valid5 = 1'b0; in_a5 = 5'd0; in_b5 = 5'd0; in_op5 = 4'd0; out_ready5 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {18'd0, out_illegal, out_result, out_zero, out_neg, out_carry, out_ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, streamed back to back at full throughput
    out_ready = 1'b1;
    tab_mode = 1'b1;
    for (int k = 0; k < 22; k++) begin
      in_valid = 1'b1; in_op = tab[k].op; in_a = tab[k].a; in_b = tab[k].b;
      tab_exp = tab[k].e;
      cycle(acc);
      chk("tab_accept", {31'd0, acc}, 32'd1);
    end
    drain();
    tab_mode = 1'b0;

    // Backpressure: four ops with the consumer stalled
    bp_ops[0] = 4'd0; bp_ops[1] = 4'd1; bp_ops[2] = 4'd8; bp_ops[3] = 4'd4;
    t0 = taken_cnt;
    out_ready = 1'b0;
    i = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_op = bp_ops[i];
      in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
      cycle(acc);
      if (acc) i++;
    end
    chk("bp_accepted", i, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) cycle(acc);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && i < 4; k++) begin
      in_valid = 1'b1; in_op = bp_ops[i];
      cycle(acc);
      if (acc) begin
        i++;
        in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255));
      end
    end
    drain();
    chk("bp_count", taken_cnt - t0, 32'd4);

    // Reset with two operations in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd0; in_a = 8'hFF; in_b = 8'h01;
    cycle(acc);
    in_op = 4'd1; in_a = 8'h01; in_b = 8'h02;
    cycle(acc);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out", {18'd0, out_illegal, out_result, out_zero, out_neg, out_carry, out_ovf}, 32'd0);
    q.delete();
    mcarry = 0;
    hold_pend = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(acc);
      chk("postrst_quiet", {31'd0, out_valid}, 32'd0);
    end
    tab_mode = 1'b1;
    tab_exp = {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    in_valid = 1'b1; in_op = 4'd8; in_a = 8'h00; in_b = 8'h00;
    cycle(acc);
    tab_mode = 1'b0;
    drain();

    // WIDTH=5: shift amounts beyond the width
    run5(4'd6,  5'h1F, 5'd6, {1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    run5(4'd7,  5'h10, 5'd5, {1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0});
    run5(4'd11, 5'h01, 5'd6, {1'b0, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0});
    run5(4'd10, 5'h10, 5'd7, {1'b0, 5'h1F, 1'b0, 1'b1, 1'b1, 1'b0});

    // Randomized traffic with random stalls on both sides
    in_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op = 4'($urandom_range(0, 15));
        in_a = 8'($urandom_range(0, 255));
        in_b = 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle(acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
